// File: rtl/fxp_pkg.sv
// Shared fixed-point constants and types for the CNN MAC datapath (default Q6.7 in 14 bits).
// Combinational definitions only: no latency, no flow control.
// Bounds below are the saturation limits used when FXP_MUL_SAT_EN is defined.
package fxp_pkg;

    localparam int FXP_WIDTH = 14;
    localparam int FXP_FRAC  = 7;

    typedef logic signed [FXP_WIDTH-1:0] fxp_t;

    localparam fxp_t FXP_MAX = {1'b0, {(FXP_WIDTH-1){1'b1}}};
    localparam fxp_t FXP_MIN = {1'b1, {(FXP_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fxp_saturate.sv
// Narrows a 2*bitsize signed value to bitsize: clamp with FXP_MUL_SAT_EN, wrap otherwise.
// Latency: purely combinational.
// Backpressure: none, output follows input.
module fxp_saturate
    import fxp_pkg::*;
#(
    parameter int bitsize = FXP_WIDTH
) (
    input  logic signed [2*bitsize-1:0] wide,
    output logic signed [bitsize-1:0]   narrow
);

`ifdef FXP_MUL_SAT_EN
    localparam logic signed [bitsize-1:0] SAT_MAX = {1'b0, {(bitsize-1){1'b1}}};
    localparam logic signed [bitsize-1:0] SAT_MIN = {1'b1, {(bitsize-1){1'b0}}};

    // The value fits when every bit above the result's sign bit repeats the sign.
    logic fits;
    assign fits = (wide[2*bitsize-1:bitsize-1] == {(bitsize+1){wide[2*bitsize-1]}});

    always_comb begin
        narrow = wide[bitsize-1:0];
        if (!fits) begin
            narrow = wide[2*bitsize-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^wide[2*bitsize-1:bitsize];
    assign narrow    = wide[bitsize-1:0];
`endif

endmodule

// File: rtl/fixed_point_multiplier.sv
// Registered signed fixed-point multiply with rescale; narrowing set by FXP_MUL_SAT_EN.
// Latency: 1 cycle from start_flag edge to Mul_result/valid; throughput 1 per cycle.
// Backpressure: none, consumer must take the result while valid is high.
module fixed_point_multiplier
    import fxp_pkg::*;
#(
    parameter int bitsize   = FXP_WIDTH,
    parameter int FRAC_BITS = FXP_FRAC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_flag,
    input  logic signed [bitsize-1:0] a,
    input  logic signed [bitsize-1:0] b,
    output logic signed [bitsize-1:0] Mul_result,
    output logic                      valid
);

    localparam int PW = 2 * bitsize;

    logic signed [PW-1:0]      a_ext;
    logic signed [PW-1:0]      b_ext;
    logic signed [PW-1:0]      prod;
    logic signed [PW-1:0]      scaled;
    logic signed [bitsize-1:0] narrowed;

    // A 2*bitsize product of sign-extended operands is the exact signed product.
    assign a_ext  = {{bitsize{a[bitsize-1]}}, a};
    assign b_ext  = {{bitsize{b[bitsize-1]}}, b};
    assign prod   = a_ext * b_ext;
    assign scaled = prod >>> FRAC_BITS;

    fxp_saturate #(
        .bitsize(bitsize)
    ) u_narrow (
        .wide  (scaled),
        .narrow(narrowed)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Mul_result <= '0;
            valid      <= 1'b0;
        end else begin
            valid <= start_flag;
            if (start_flag) begin
                Mul_result <= narrowed;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Self-checking bench for fixed_point_multiplier (default Q6.7); expectations follow FXP_MUL_SAT_EN.
module tb_fixed_point_multiplier;

    localparam int W = 14;
    localparam int F = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_flag;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] mul_result;
    logic         valid;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fixed_point_multiplier #(
        .bitsize  (W),
        .FRAC_BITS(F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_flag(start_flag),
        .a         (a),
        .b         (b),
        .Mul_result(mul_result),
        .valid     (valid)
    );

    // Reference: exact integer product, floor-divide by 2^F, then clamp or wrap.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, p, s, scale, hi, lo;
        logic [63:0] bits;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        p     = sx * sy;
        scale = longint'(1) << F;
        s     = p / scale;
        if (p < 0 && (p % scale) != 0) s = s - 1;
        hi = (longint'(1) << (W - 1)) - 1;
        lo = -(longint'(1) << (W - 1));
`ifdef FXP_MUL_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`else
        if (hi < lo) s = 0;
`endif
        bits = s;
        return bits[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_op();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: return 14'h2000;
            1: return 14'h1FFF;
            2: return 14'h0000;
            3: return 14'h3FFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic st);
        @(negedge clk);
        a          = x;
        b          = y;
        start_flag = st;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        start_flag = 1'b1;
        a          = W'($urandom);
        b          = W'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mul_result !== '0) $display("FAIL reset_result: got %h expected %h", mul_result, 14'h0);
            else passed++;
            checks++;
            if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid);
            else passed++;
        end
        @(negedge clk);
        a   = 14'h3F27;
        b   = 14'h3F27;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mul_result !== 14'd367) $display("FAIL sign_cancel: got %h expected %h", mul_result, 14'd367);
        else passed++;
        checks++;
        if (valid !== 1'b1) $display("FAIL sign_cancel_valid: got %b expected 1", valid);
        else passed++;
    endtask

    task automatic test_directed();
        logic [W-1:0] va[7];
        logic [W-1:0] vb[7];
        logic [W-1:0] ve[7];
        va[0] = 14'h0100; vb[0] = 14'h0180; ve[0] = 14'h0300;
        va[1] = 14'h3FC0; vb[1] = 14'h0040; ve[1] = 14'h3FE0;
        va[2] = 14'h3FFF; vb[2] = 14'h0001; ve[2] = 14'h3FFF;
        va[3] = 14'h0000; vb[3] = 14'h2000; ve[3] = 14'h0000;
        va[4] = 14'h2000; vb[4] = 14'h0080; ve[4] = 14'h2000;
`ifdef FXP_MUL_SAT_EN
        va[5] = 14'h1400; vb[5] = 14'h0100; ve[5] = 14'h1FFF;
        va[6] = 14'h2000; vb[6] = 14'h2000; ve[6] = 14'h1FFF;
`else
        va[5] = 14'h1400; vb[5] = 14'h0100; ve[5] = 14'h2800;
        va[6] = 14'h2000; vb[6] = 14'h2000; ve[6] = 14'h0000;
`endif
        for (int i = 0; i < 7; i++) begin
            apply(va[i], vb[i], 1'b1);
            checks++;
            if (mul_result !== ve[i])
                $display("FAIL directed_%0d: a=%h b=%h got %h expected %h", i, va[i], vb[i], mul_result, ve[i]);
            else passed++;
        end
    endtask

    task automatic test_handshake();
        logic [W-1:0] x, y, held;
        x    = rand_op();
        y    = rand_op();
        held = model(x, y);
        apply(x, y, 1'b1);
        checks++;
        if (valid !== 1'b1 || mul_result !== held)
            $display("FAIL pulse_capture: got %b/%h expected 1/%h", valid, mul_result, held);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            apply(rand_op(), rand_op(), 1'b0);
            checks++;
            if (valid !== 1'b0 || mul_result !== held)
                $display("FAIL pulse_hold_%0d: got %b/%h expected 0/%h", i, valid, mul_result, held);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y, e;
        for (int i = 0; i < 20; i++) begin
            x = rand_op();
            y = rand_op();
            e = model(x, y);
            apply(x, y, 1'b1);
            checks++;
            if (valid !== 1'b1 || mul_result !== e)
                $display("FAIL b2b_%0d: a=%h b=%h got %b/%h expected 1/%h", i, x, y, valid, mul_result, e);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        apply(14'h0100, 14'h0180, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mul_result !== '0 || valid !== 1'b0)
            $display("FAIL async_reset: got %b/%h expected 0/%h", valid, mul_result, 14'h0);
        else passed++;
        @(negedge clk);
        rst        = 1'b1;
        start_flag = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mul_result !== '0 || valid !== 1'b0)
            $display("FAIL post_reset_idle: got %b/%h expected 0/%h", valid, mul_result, 14'h0);
        else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, held;
        logic st;
        held = mul_result;
        for (int i = 0; i < 300; i++) begin
            x  = rand_op();
            y  = rand_op();
            st = 1'($urandom_range(0, 1));
            if (st) held = model(x, y);
            apply(x, y, st);
            checks++;
            if (valid !== st || mul_result !== held)
                $display("FAIL random_%0d: a=%h b=%h st=%b got %b/%h expected %b/%h",
                         i, x, y, st, valid, mul_result, st, held);
            else passed++;
        end
    endtask

    initial begin
        start_flag = 1'b0;
        a          = '0;
        b          = '0;
        test_reset();
        test_directed();
        test_handshake();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
